// File: rtl/hyperbus_pkg.sv
// Shared definitions for the HyperBus responder: FSM states, CA bit positions,
// default latency and the CA-to-word-address helper.
package hyperbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_WDATA,
    ST_RDATA
  } hb_state_e;

  localparam int unsigned CA_RW = 47;
  localparam int unsigned CA_AS = 46;
  localparam int unsigned CA_BT = 45;

  localparam int unsigned DEFAULT_LATENCY = 6;

  // Row address (CA[44:16]) concatenated with the column word (CA[2:0]).
  function automatic logic [31:0] ca_word_addr(input logic [28:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/hyperbus_resp_mem.sv
// Single-port synchronous word RAM with independent high/low byte write enables.
// Contents are deliberately not reset.
module hyperbus_resp_mem #(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [15:0]          wdata,
  input  logic                 we_hi,
  input  logic                 we_lo,
  output logic [15:0]          rdata
);

  logic [15:0] mem_q [2**ADDR_BITS];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_hi) mem_q[addr][15:8] <= wdata[15:8];
    if (we_lo) mem_q[addr][7:0]  <= wdata[7:0];
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hyperbus_responder.sv
// HyperBus memory responder: 3-cycle CA capture, fixed latency, linear wrapping bursts.
// Build option HYPERBUS_RESP_DOUBLE_LATENCY_EN doubles latency and drives RWDS high during CA.
module hyperbus_responder
  import hyperbus_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LATENCY   = DEFAULT_LATENCY,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cs_n,
  input  logic [2*WIDTH-1:0] dq_i,
  input  logic [1:0]         rwds_i,
  output logic [2*WIDTH-1:0] dq_o,
  output logic               dq_oe,
  output logic [1:0]         rwds_o,
  output logic               rwds_oe
);

`ifdef HYPERBUS_RESP_DOUBLE_LATENCY_EN
  localparam int unsigned LAT_CYC    = 2 * LATENCY;
  localparam bit          CA_RWDS_EN = 1'b1;
`else
  localparam int unsigned LAT_CYC    = LATENCY;
  localparam bit          CA_RWDS_EN = 1'b0;
`endif
  localparam logic [15:0] LAT_LAST = 16'(LAT_CYC - 1);

  hb_state_e            state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [47:0]          ca_q, ca_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;

  logic [15:0]          bus_word;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [15:0]          mem_rdata;
  logic                 mem_we_hi, mem_we_lo;
  logic                 active;

  // First-edge byte is the most significant byte of every bus word.
  always_comb bus_word = {dq_i[WIDTH-1:0], dq_i[2*WIDTH-1:WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ca_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ca_q    <= ca_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!cs_n) state_d = ST_CA;
      ST_CA:    if (cnt_q == 16'd1) state_d = ST_LAT;
      ST_LAT:   if (cnt_q == LAT_LAST) state_d = ca_q[CA_RW] ? ST_RDATA : ST_WDATA;
      default:  ;
    endcase
    if (cs_n) state_d = ST_IDLE;
  end

  always_comb begin
    cnt_d  = cnt_q;
    ca_d   = ca_q;
    addr_d = addr_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        ca_d  = {bus_word, 32'h0};
      end
      ST_CA: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'd0) begin
          ca_d[31:16] = bus_word;
        end else begin
          // Address is loaded as the last CA word arrives so LAT can prefetch from its first cycle.
          ca_d[15:0] = bus_word;
          cnt_d      = '0;
          addr_d     = ADDR_BITS'(ca_word_addr(ca_d[44:16], ca_d[2:0]));
        end
      end
      ST_LAT:   cnt_d = cnt_q + 16'd1;
      ST_WDATA,
      ST_RDATA: addr_d = addr_q + ADDR_BITS'(1);
      default:  ;
    endcase
    if (cs_n) begin
      cnt_d = '0;
      ca_d  = '0;
    end
  end

  always_comb begin
    active  = rst_n && !cs_n;
    dq_oe   = 1'b0;
    dq_o    = '0;
    rwds_oe = 1'b0;
    rwds_o  = '0;
    if (active) begin
      case (state_q)
        ST_RDATA: begin
          dq_oe   = 1'b1;
          dq_o    = {mem_rdata[7:0], mem_rdata[15:8]};
          rwds_oe = 1'b1;
          rwds_o  = 2'b01;
        end
        ST_IDLE, ST_CA: begin
          if (CA_RWDS_EN) begin
            rwds_oe = 1'b1;
            rwds_o  = 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

  // During RDATA the RAM is addressed one word ahead so the next word is ready without a bubble.
  always_comb begin
    mem_addr  = (state_q == ST_RDATA) ? addr_q + ADDR_BITS'(1) : addr_q;
    mem_we_hi = active && (state_q == ST_WDATA) && !rwds_i[0];
    mem_we_lo = active && (state_q == ST_WDATA) && !rwds_i[1];
  end

  hyperbus_resp_mem #(
    .ADDR_BITS(ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .addr  (mem_addr),
    .wdata (bus_word),
    .we_hi (mem_we_hi),
    .we_lo (mem_we_lo),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_hyperbus_responder.sv
// Randomized self-checking bench for hyperbus_responder against a byte-level memory model.
module tb_hyperbus_responder;

  localparam int unsigned LATENCY   = 6;
  localparam int unsigned ADDR_BITS = 10;
  localparam int unsigned DEPTH     = 1 << ADDR_BITS;
`ifdef HYPERBUS_RESP_DOUBLE_LATENCY_EN
  localparam int unsigned LAT_CYC = 2 * LATENCY;
  localparam bit          CA_RWDS = 1'b1;
`else
  localparam int unsigned LAT_CYC = LATENCY;
  localparam bit          CA_RWDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic [15:0] dq_i = '0;
  logic [1:0]  rwds_i = '0;
  logic [15:0] dq_o;
  logic        dq_oe;
  logic [1:0]  rwds_o;
  logic        rwds_oe;

  always #5 clk = ~clk;

  hyperbus_responder #(
    .WIDTH(8),
    .LATENCY(LATENCY),
    .ADDR_BITS(ADDR_BITS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cs_n(cs_n),
    .dq_i(dq_i),
    .rwds_i(rwds_i),
    .dq_o(dq_o),
    .dq_oe(dq_oe),
    .rwds_o(rwds_o),
    .rwds_oe(rwds_oe)
  );

  // Reference memory: word value with per-byte "known" flags.
  logic [15:0] ref_mem [DEPTH];
  bit          ref_vhi [DEPTH];
  bit          ref_vlo [DEPTH];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0] wq [$];
  logic [1:0]  mq [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_dq_oe"},   32'(dq_oe),   32'd0);
    check_eq({tag, "_dq_o"},    32'(dq_o),    32'd0);
    check_eq({tag, "_rwds_oe"}, 32'(rwds_oe), 32'd0);
    check_eq({tag, "_rwds_o"},  32'(rwds_o),  32'd0);
  endtask

  function automatic logic [47:0] make_ca(input bit rd, input int unsigned addr);
    logic [47:0] ca;
    ca[47:16] = $urandom();
    ca[15:0]  = 16'($urandom());
    ca[47]    = rd;
    ca[22:16] = 7'(addr >> 3);
    ca[2:0]   = 3'(addr);
    return ca;
  endfunction

  task automatic drive_ca(input logic [47:0] ca, input int unsigned ncyc);
    logic [15:0] w;
    for (int k = 0; k < int'(ncyc); k++) begin
      @(negedge clk);
      cs_n   = 1'b0;
      w      = ca[47-16*k -: 16];
      dq_i   = {w[7:0], w[15:8]};
      rwds_i = 2'($urandom());
      #2;
      check_eq("ca_dq_oe",   32'(dq_oe),   32'd0);
      check_eq("ca_rwds_oe", 32'(rwds_oe), 32'(CA_RWDS));
      check_eq("ca_rwds_o",  32'(rwds_o),  CA_RWDS ? 32'd3 : 32'd0);
    end
  endtask

  // One burst; rst_at >= 0 asserts reset during that data word and returns after release.
  task automatic xfer(input bit rd, input int unsigned addr, input int unsigned n, input int rst_at);
    logic [15:0] d;
    logic [1:0]  m;
    int unsigned a;
    drive_ca(make_ca(rd, addr), 3);
    for (int j = 0; j < int'(LAT_CYC); j++) begin
      @(negedge clk);
      dq_i   = 16'($urandom());
      rwds_i = 2'($urandom());
      #2;
      check_eq("lat_dq_oe",   32'(dq_oe),   32'd0);
      check_eq("lat_rwds_oe", 32'(rwds_oe), 32'd0);
    end
    for (int i = 0; i < int'(n); i++) begin
      @(negedge clk);
      a = (addr + i) % DEPTH;
      if (!rd && wq.size() > 0) begin
        d = wq.pop_front();
        m = mq.pop_front();
      end else begin
        d = 16'($urandom());
        m = ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b00;
      end
      dq_i   = d;
      rwds_i = m;
      #2;
      if (i == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        check_quiet("rst_async");
        repeat (2) @(negedge clk);
        #2;
        check_quiet("rst_hold");
        @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      if (rd) begin
        check_eq("rd_dq_oe",   32'(dq_oe),   32'd1);
        check_eq("rd_rwds_oe", 32'(rwds_oe), 32'd1);
        check_eq("rd_rwds_o",  32'(rwds_o),  32'd1);
        if (ref_vhi[a] && ref_vlo[a])
          check_eq("rd_data", 32'(dq_o), 32'({ref_mem[a][7:0], ref_mem[a][15:8]}));
      end else begin
        check_eq("wr_dq_oe",   32'(dq_oe),   32'd0);
        check_eq("wr_rwds_oe", 32'(rwds_oe), 32'd0);
        if (!m[0]) begin ref_mem[a][15:8] = d[7:0];  ref_vhi[a] = 1'b1; end
        if (!m[1]) begin ref_mem[a][7:0]  = d[15:8]; ref_vlo[a] = 1'b1; end
      end
    end
    @(negedge clk);
    cs_n = 1'b1;
    dq_i = 16'($urandom());
    #2;
    check_quiet("end");
  endtask

  task automatic push_word(input logic [15:0] word, input logic [1:0] msk);
    wq.push_back({word[7:0], word[15:8]});
    mq.push_back(msk);
  endtask

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      ref_vhi[i] = 1'b0;
      ref_vlo[i] = 1'b0;
    end

    repeat (2) @(negedge clk);
    cs_n = 1'b0;
    dq_i = 16'hFFFF;
    #2;
    check_quiet("reset");
    cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Single word round trip at 0x010.
    push_word(16'hA55A, 2'b00);
    xfer(1'b0, 'h010, 1, -1);
    xfer(1'b1, 'h010, 1, -1);

    // Wrapping burst across the top of memory.
    push_word(16'h1111, 2'b00);
    push_word(16'h2222, 2'b00);
    push_word(16'h3333, 2'b00);
    push_word(16'h4444, 2'b00);
    xfer(1'b0, 'h3FE, 4, -1);
    xfer(1'b1, 'h3FE, 4, -1);
    xfer(1'b1, 'h000, 2, -1);

    // Byte-masked write.
    push_word(16'h0000, 2'b00);
    xfer(1'b0, 'h020, 1, -1);
    wq.push_back(16'hBEEF);
    mq.push_back(2'b10);
    xfer(1'b0, 'h020, 1, -1);
    xfer(1'b1, 'h020, 1, -1);

    // Write aborted after two CA cycles, then a normal read.
    drive_ca(make_ca(1'b0, 'h010), 2);
    @(negedge clk);
    cs_n = 1'b1;
    #2;
    check_quiet("abort");
    @(negedge clk);
    #2;
    check_quiet("abort_idle");
    xfer(1'b1, 'h010, 1, -1);

    // Reset during word 2 of a 4-word read; cs_n stays low and a fresh CA follows.
    for (int i = 0; i < 4; i++) push_word(16'(32'hC0DE + i * 32'h1111), 2'b00);
    xfer(1'b0, 'h100, 4, -1);
    xfer(1'b1, 'h100, 4, 1);
    xfer(1'b1, 'h100, 4, -1);

    // Reset during word 3 of a write: later words must not land.
    for (int i = 0; i < 4; i++) push_word(16'(32'h0F00 + i), 2'b00);
    xfer(1'b0, 'h200, 4, -1);
    for (int i = 0; i < 4; i++) push_word(16'(32'h7700 + i), 2'b00);
    xfer(1'b0, 'h200, 4, 2);
    wq.delete();
    mq.delete();
    xfer(1'b1, 'h200, 4, -1);

    // Random traffic concentrated in a small window so reads hit written words.
    for (int t = 0; t < 40; t++) begin
      xfer(1'($urandom_range(0, 1)), 'h3F8 + $urandom_range(0, 15),
           $urandom_range(1, 6), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
